fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch front end. A fetch PC issues single-beat
//                reads to a 1-cycle instruction memory, and responses are
//                buffered in a small circular queue that feeds decode through
//                a valid/ready handshake. Redirects flush the pipe.
//                Optional macro FETCH_BYPASS_EN presents a response directly
//                on out_* when the queue is empty (1-cycle fetch latency).
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h8000_0000),
    parameter int                PC_STEP  = 4,
    parameter int                FQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst
);

    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic              infl_q, infl_d;
    logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] pc_mem   [FQ_DEPTH];
    logic [INST_W-1:0] inst_mem [FQ_DEPTH];

    logic w_empty;
    logic w_credit;
    logic w_bypass;
    logic w_enq;
    logic w_deq;

    assign w_empty  = (count_q == '0);
    // Queue occupancy plus the outstanding read must leave room for the response.
    assign w_credit = ((count_q + CNT_W'(infl_q)) < CNT_W'(FQ_DEPTH));

    assign imem_req  = !rst && !redir_valid && w_credit;
    assign imem_addr = fpc_q;

`ifdef FETCH_BYPASS_EN
    assign w_bypass = infl_q && w_empty && !rst && !redir_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign out_valid = !w_empty || w_bypass;
    assign out_pc    = w_bypass ? infl_pc_q  : pc_mem[rd_ptr_q];
    assign out_inst  = w_bypass ? imem_rdata : inst_mem[rd_ptr_q];

    // A bypassed response that decode takes immediately never touches the queue.
    assign w_deq = out_valid && out_ready && !w_bypass;
    assign w_enq = infl_q && !(w_bypass && out_ready);

    always_comb begin
        fpc_d     = fpc_q;
        infl_d    = infl_q;
        infl_pc_d = infl_pc_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        if (redir_valid) begin
            fpc_d    = redir_pc;
            infl_d   = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            infl_d = imem_req;
            if (imem_req) begin
                infl_pc_d = fpc_q;
                fpc_d     = fpc_q + ADDR_W'(PC_STEP);
            end
            if (w_enq) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(w_enq) - CNT_W'(w_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q     <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            fpc_q     <= fpc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Payload storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (!rst && !redir_valid && w_enq) begin
            pc_mem[wr_ptr_q]   <= infl_pc_q;
            inst_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire
